// File: rtl/signal_pkg.sv
// Shared types for the light-signal sequencer: phase colours, FSM states, one-hot decode.
// Pure declarations; no latency or backpressure of its own.
package signal_pkg;

    typedef enum logic [1:0] {
        GAP    = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2,
        RED    = 2'd3
    } color_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    // Bit order is {red, yellow, green}; GAP decodes to all lamps off.
    function automatic logic [2:0] color_onehot(input color_t c);
        logic [2:0] oh;
        oh = 3'b000;
        case (c)
            GREEN:   oh = 3'b001;
            YELLOW:  oh = 3'b010;
            RED:     oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Phase-command FIFO, DEPTH x WIDTH, head visible combinationally (zero read latency).
// Pushes while full and pops while empty are ignored; full is the upstream backpressure.
module cmd_fifo
    import signal_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB separates "wrapped once" (full) from "caught up" (empty).
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
        end
    end

endmodule

// File: rtl/signal_sequencer.sv
// Plays queued (colour, duration) phases back-to-back onto one-hot lamp outputs.
// Command to lamp: one cycle from an idle empty queue; cmd_ready = !fifo_full.
module signal_sequencer
    import signal_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DUR_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_color,
    input  logic [DUR_W-1:0] cmd_dur,
    output logic             green,
    output logic             yellow,
    output logic             red,
    output logic [DUR_W-1:0] phase_timer,
    output logic             phase_done,
    output logic             busy,
    output logic             underrun
);

    localparam int CMD_W = 2 + DUR_W;
    localparam logic [DUR_W-1:0] DUR_ONE = {{(DUR_W-1){1'b0}}, 1'b1};

    seq_state_t       state_q;
    seq_state_t       state_d;
    logic [DUR_W-1:0] timer_q;
    logic [DUR_W-1:0] timer_d;
    logic [2:0]       color_q;
    logic [2:0]       color_d;
    logic             underrun_q;
    logic             underrun_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic [CMD_W-1:0] fifo_head;
    logic             fifo_pop;
    logic             load;
    color_t           head_color;
    logic [DUR_W-1:0] head_dur;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (cmd_valid),
        .push_dat ({cmd_color, cmd_dur}),
        .pop      (fifo_pop),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign head_color = color_t'(fifo_head[DUR_W +: 2]);
    assign head_dur   = fifo_head[DUR_W-1:0];

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        color_d    = color_q;
        underrun_d = underrun_q;
        load       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    load = 1'b1;
                end
            end
            RUN: begin
                if (timer_q == DUR_ONE) begin
                    if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        timer_d = '0;
                        color_d = 3'b000;
                        // A GAP phase has no lamp lit, so running dry after it is benign.
                        if (|color_q) begin
                            underrun_d = 1'b1;
                        end
                    end
                end else begin
                    timer_d = timer_q - DUR_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Loading the next phase on the final edge of the current one leaves no gap cycle.
        if (load) begin
            state_d = RUN;
            timer_d = (head_dur == '0) ? DUR_ONE : head_dur;
            color_d = color_onehot(head_color);
        end
        fifo_pop = load;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            color_q    <= 3'b000;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            color_q    <= color_d;
            underrun_q <= underrun_d;
        end
    end

    assign cmd_ready   = !fifo_full;
    assign green       = color_q[0];
    assign yellow      = color_q[1];
    assign red         = color_q[2];
    assign phase_timer = timer_q;
    assign busy        = (state_q == RUN);
    assign phase_done  = (state_q == RUN) && (timer_q == DUR_ONE);
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_signal_sequencer.sv
// Bench for signal_sequencer: directed scenarios plus a randomized run against a phase-list model.
module tb_signal_sequencer;

    localparam int DEPTH = 4;
    localparam int DUR_W = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic [1:0]       cmd_color = 2'd0;
    logic [DUR_W-1:0] cmd_dur = '0;
    logic             cmd_ready;
    logic             green;
    logic             yellow;
    logic             red;
    logic [DUR_W-1:0] phase_timer;
    logic             phase_done;
    logic             busy;
    logic             underrun;

    int checks = 0;
    int errors = 0;

    // Observed busy-cycle trace and the expected one built from phase lists.
    logic [2:0] cap_col[$];
    int         cap_tmr[$];
    logic       cap_done[$];
    bit         cap_to;
    logic [2:0] exp_col[$];
    int         exp_tmr[$];

    signal_sequencer #(.DEPTH(DEPTH), .DUR_W(DUR_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_color   (cmd_color),
        .cmd_dur     (cmd_dur),
        .green       (green),
        .yellow      (yellow),
        .red         (red),
        .phase_timer (phase_timer),
        .phase_done  (phase_done),
        .busy        (busy),
        .underrun    (underrun)
    );

    always #5 clock = ~clock;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Lamp vector {red, yellow, green} for colour code c.
    function automatic logic [2:0] lamp(input int c);
        if (c == 0) return 3'b000;
        return 3'(1 << (c - 1));
    endfunction

    function automatic int eff_dur(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic expand(input int c, input int d);
        for (int t = eff_dur(d); t >= 1; t--) begin
            exp_col.push_back(lamp(c));
            exp_tmr.push_back(t);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    // Presents one command until accepted; returns at posedge+1.
    task automatic push_cmd(input int c, input int d, output bit ok);
        int w;
        bit r;
        w = 0;
        ok = 1'b0;
        cmd_valid = 1'b1;
        cmd_color = 2'(c);
        cmd_dur = DUR_W'(d);
        while (!ok && w < 300) begin
            r = cmd_ready;
            @(posedge clock);
            #1;
            if (r) ok = 1'b1;
            w++;
        end
        cmd_valid = 1'b0;
    endtask

    // Records every busy cycle from the first busy cycle until busy falls.
    task automatic capture(input int max_wait, input int max_len);
        int w;
        w = 0;
        cap_col.delete();
        cap_tmr.delete();
        cap_done.delete();
        cap_to = 1'b0;
        @(negedge clock);
        while (!busy) begin
            w++;
            if (w > max_wait) begin
                cap_to = 1'b1;
                return;
            end
            @(negedge clock);
        end
        while (busy) begin
            cap_col.push_back({red, yellow, green});
            cap_tmr.push_back(int'(phase_timer));
            cap_done.push_back(phase_done);
            if (cap_col.size() > max_len) begin
                cap_to = 1'b1;
                return;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clock);
        checks++;
        if ({red, yellow, green} !== 3'b000) begin
            errors++; $display("FAIL reset_lamps: got %b want 000", {red, yellow, green});
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (phase_timer !== '0) begin errors++; $display("FAIL reset_timer: got %0d want 0", phase_timer); end
        checks++;
        if (phase_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", phase_done); end
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", underrun); end
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_latency();
        bit ok;
        do_reset();
        push_cmd(1, 5, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL lat_push: got not-accepted want accepted"); end
        @(negedge clock);
        checks++;
        if (green !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL lat_edge_k: got green=%b busy=%b want 0 0", green, busy);
        end
        @(negedge clock);
        checks++;
        if (green !== 1'b1 || phase_timer !== 8'd5 || busy !== 1'b1) begin
            errors++; $display("FAIL lat_first_run: got green=%b timer=%0d busy=%b want 1 5 1", green, phase_timer, busy);
        end
        repeat (4) @(negedge clock);
        checks++;
        if (green !== 1'b1 || phase_timer !== 8'd1 || phase_done !== 1'b1) begin
            errors++; $display("FAIL lat_last_cycle: got green=%b timer=%0d done=%b want 1 1 1", green, phase_timer, phase_done);
        end
        @(negedge clock);
        checks++;
        if (green !== 1'b0 || busy !== 1'b0 || phase_timer !== '0 || underrun !== 1'b1) begin
            errors++; $display("FAIL lat_after: got green=%b busy=%b timer=%0d underrun=%b want 0 0 0 1", green, busy, phase_timer, underrun);
        end
    endtask

    task automatic test_sequence();
        bit ok0, ok1, ok2;
        int dones, lows;
        do_reset();
        exp_col.delete(); exp_tmr.delete();
        expand(1, 40); expand(3, 12); expand(1, 120);
        fork
            begin push_cmd(1, 40, ok0); push_cmd(3, 12, ok1); push_cmd(1, 120, ok2); end
            capture(20, 400);
        join
        checks++;
        if (!(ok0 && ok1 && ok2) || cap_to) begin
            errors++; $display("FAIL seq_flow: got push_ok=%b%b%b timeout=%b want 111 0", ok0, ok1, ok2, cap_to);
        end
        checks++;
        if (cap_col.size() != exp_col.size()) begin
            errors++; $display("FAIL seq_len: got %0d busy cycles want %0d", cap_col.size(), exp_col.size());
        end else begin
            foreach (exp_col[i]) begin
                if (cap_col[i] !== exp_col[i] || cap_tmr[i] != exp_tmr[i] || cap_done[i] !== (exp_tmr[i] == 1)) begin
                    errors++;
                    $display("FAIL seq_trace: cycle %0d got lamps=%b timer=%0d done=%b want %b %0d %b",
                             i, cap_col[i], cap_tmr[i], cap_done[i], exp_col[i], exp_tmr[i], exp_tmr[i] == 1);
                    break;
                end
            end
        end
        dones = 0; lows = 0;
        foreach (cap_done[i]) begin
            if (cap_done[i]) dones++;
            if (cap_col[i] == 3'b000) lows++;
        end
        checks++;
        if (dones != 3) begin errors++; $display("FAIL seq_done_count: got %0d want 3", dones); end
        checks++;
        if (lows != 0) begin errors++; $display("FAIL seq_low_cycles: got %0d want 0", lows); end
        checks++;
        if (underrun !== 1'b1) begin errors++; $display("FAIL seq_underrun: got %b want 1", underrun); end
    endtask

    task automatic test_gap();
        bit ok0, ok1, ok2;
        do_reset();
        exp_col = '{3'b010, 3'b000, 3'b000, 3'b000, 3'b100, 3'b100};
        exp_tmr = '{1, 3, 2, 1, 2, 1};
        fork
            begin push_cmd(2, 0, ok0); push_cmd(0, 3, ok1); push_cmd(3, 2, ok2); end
            capture(20, 100);
        join
        checks++;
        if (!(ok0 && ok1 && ok2) || cap_to) begin
            errors++; $display("FAIL gap_flow: got push_ok=%b%b%b timeout=%b want 111 0", ok0, ok1, ok2, cap_to);
        end
        checks++;
        if (cap_col.size() != exp_col.size()) begin
            errors++; $display("FAIL gap_len: got %0d busy cycles want %0d", cap_col.size(), exp_col.size());
        end else begin
            foreach (exp_col[i]) begin
                if (cap_col[i] !== exp_col[i] || cap_tmr[i] != exp_tmr[i] || cap_done[i] !== (exp_tmr[i] == 1)) begin
                    errors++;
                    $display("FAIL gap_trace: cycle %0d got lamps=%b timer=%0d done=%b want %b %0d %b",
                             i, cap_col[i], cap_tmr[i], cap_done[i], exp_col[i], exp_tmr[i], exp_tmr[i] == 1);
                    break;
                end
            end
        end
        checks++;
        if (underrun !== 1'b1) begin errors++; $display("FAIL gap_underrun: got %b want 1", underrun); end
    endtask

    task automatic test_back_to_back();
        int cc[7];
        int dd[7];
        int low_at;
        bit drv_to;
        do_reset();
        cc[0] = 3; dd[0] = 50;
        for (int i = 1; i < 7; i++) begin
            cc[i] = $urandom_range(0, 3);
            dd[i] = $urandom_range(1, 8);
        end
        exp_col.delete(); exp_tmr.delete();
        for (int i = 0; i < 7; i++) expand(cc[i], dd[i]);
        low_at = -1;
        drv_to = 1'b0;
        fork
            begin
                for (int i = 0; i < 7; i++) begin
                    int w;
                    bit r;
                    w = 0;
                    cmd_valid = 1'b1;
                    cmd_color = 2'(cc[i]);
                    cmd_dur = DUR_W'(dd[i]);
                    forever begin
                        r = cmd_ready;
                        if (!r && low_at < 0) low_at = i - 1;
                        @(posedge clock);
                        #1;
                        if (r) break;
                        w++;
                        if (w > 300) begin drv_to = 1'b1; break; end
                    end
                    if (drv_to) break;
                end
                cmd_valid = 1'b0;
            end
            capture(20, 2000);
        join
        checks++;
        if (drv_to || cap_to) begin
            errors++; $display("FAIL b2b_flow: got drive_timeout=%b capture_timeout=%b want 0 0", drv_to, cap_to);
        end
        checks++;
        if (low_at != DEPTH) begin
            errors++; $display("FAIL b2b_ready_drop: got ready low after %0d held commands want %0d", low_at, DEPTH);
        end
        checks++;
        if (cap_col.size() != exp_col.size()) begin
            errors++; $display("FAIL b2b_len: got %0d busy cycles want %0d", cap_col.size(), exp_col.size());
        end else begin
            foreach (exp_col[i]) begin
                if (cap_col[i] !== exp_col[i] || cap_tmr[i] != exp_tmr[i]) begin
                    errors++;
                    $display("FAIL b2b_trace: cycle %0d got lamps=%b timer=%0d want %b %0d",
                             i, cap_col[i], cap_tmr[i], exp_col[i], exp_tmr[i]);
                    break;
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok0, ok1, ok2;
        int w, active;
        do_reset();
        push_cmd(1, 40, ok0); push_cmd(3, 5, ok1); push_cmd(2, 5, ok2);
        checks++;
        if (!(ok0 && ok1 && ok2)) begin
            errors++; $display("FAIL rst_mid_push: got push_ok=%b%b%b want 111", ok0, ok1, ok2);
        end
        w = 0;
        @(negedge clock);
        while (!(green === 1'b1 && phase_timer == 8'd21) && w < 100) begin
            @(negedge clock);
            w++;
        end
        checks++;
        if (w >= 100) begin errors++; $display("FAIL rst_mid_reach: got no cycle 20 of green within %0d cycles want reached", w); end
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({red, yellow, green} !== 3'b000 || phase_timer !== '0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_state: got lamps=%b timer=%0d busy=%b ready=%b want 000 0 0 1",
                     {red, yellow, green}, phase_timer, busy, cmd_ready);
        end
        active = 0;
        repeat (100) begin
            @(negedge clock);
            if (busy || green || yellow || red) active++;
        end
        checks++;
        if (active != 0) begin errors++; $display("FAIL rst_mid_replay: got %0d active cycles want 0", active); end
    endtask

    task automatic test_random();
        logic [2:0] rq_col[$];
        int         rq_tmr[$];
        bit         mon_on, drv_to, oh_bad, seq_bad;
        do_reset();
        mon_on = 1'b1; drv_to = 1'b0; oh_bad = 1'b0; seq_bad = 1'b0;
        fork
            begin
                int w;
                for (int n = 0; n < 10000; n++) begin
                    int c, d;
                    bit ok;
                    c = $urandom_range(0, 3);
                    d = $urandom_range(0, 3);
                    while ($urandom_range(0, 3) == 0) begin
                        @(posedge clock);
                        #1;
                    end
                    push_cmd(c, d, ok);
                    if (!ok) begin drv_to = 1'b1; break; end
                    for (int t = eff_dur(d); t >= 1; t--) begin
                        rq_col.push_back(lamp(c));
                        rq_tmr.push_back(t);
                    end
                end
                w = 0;
                while (rq_col.size() > 0 && w < 5000) begin
                    @(posedge clock);
                    w++;
                end
                repeat (3) @(posedge clock);
                mon_on = 1'b0;
            end
            begin
                while (mon_on) begin
                    @(negedge clock);
                    if (!oh_bad) begin
                        checks++;
                        if ($countones({red, yellow, green}) > 1) begin
                            errors++; oh_bad = 1'b1;
                            $display("FAIL rand_onehot: got lamps=%b want at most one high", {red, yellow, green});
                        end
                    end
                    if (busy && !seq_bad) begin
                        checks++;
                        if (rq_col.size() == 0) begin
                            errors++; seq_bad = 1'b1;
                            $display("FAIL rand_extra: got busy cycle lamps=%b want no pending phase", {red, yellow, green});
                        end else if ({red, yellow, green} !== rq_col[0] || int'(phase_timer) != rq_tmr[0]
                                     || phase_done !== (rq_tmr[0] == 1)) begin
                            errors++; seq_bad = 1'b1;
                            $display("FAIL rand_trace: got lamps=%b timer=%0d done=%b want %b %0d %b",
                                     {red, yellow, green}, phase_timer, phase_done, rq_col[0], rq_tmr[0], rq_tmr[0] == 1);
                        end else begin
                            void'(rq_col.pop_front());
                            void'(rq_tmr.pop_front());
                        end
                    end
                end
            end
        join
        checks++;
        if (drv_to) begin errors++; $display("FAIL rand_drive: got command stuck want accepted"); end
        checks++;
        if (!seq_bad && rq_col.size() != 0) begin
            errors++; $display("FAIL rand_drain: got %0d phase cycles never played want 0", rq_col.size());
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_sequence();
        test_gap();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
